vram_dma_controller: RTL and testbench

- Bulk-copies up to 256 bytes from a CPU-space source page into VRAM during vertical blank, so software can refresh tile or sprite tables without byte-by-byte CPU stores.
- Sits beside the GPU and owns the single VRAM write port.
- Arbitrates that port between direct CPU VRAM writes and its own DMA writes.
- Fetches source bytes through a req/ack read interface served by the RAM/ROM side of the bus.

---
 rtl/vram_dma_controller.sv | 100 ++++++++++
 tb/tb_vram_dma_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_dma_controller.sv
// vram_dma_controller: vblank-gated page-to-VRAM block copier that shares the VRAM write port with the CPU
module vram_dma_controller #(
  parameter int VRAM_ADDR_W = 12,
  parameter int SRC_ADDR_W  = 16
) (
  input  logic                   clk_12_5875,
  input  logic                   rst_B,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_addr,
  input  logic [7:0]             cfg_data,
  input  logic                   done_clr,
  input  logic                   in_vblank,
  output logic                   src_req,
  output logic [SRC_ADDR_W-1:0]  src_addr,
  input  logic                   src_ack,
  input  logic [7:0]             src_data,
  input  logic                   cpu_vram_we,
  input  logic [VRAM_ADDR_W-1:0] cpu_vram_addr,
  input  logic [7:0]             cpu_vram_data,
  output logic                   vram_we,
  output logic [VRAM_ADDR_W-1:0] vram_addr,
  output logic [7:0]             vram_data,
  output logic                   busy,
  output logic                   done_irq
);
  localparam int PW = SRC_ADDR_W - 8;
  localparam logic [2:0] IDLE = 3'd0, ARMED = 3'd1, FETCH = 3'd2, WRITE = 3'd3, DONE = 3'd4;
  logic [2:0]             state_q, state_d;
  logic [PW-1:0]          page_q, page_d;
  logic [VRAM_ADDR_W-1:0] dst_q, dst_d;
  logic [8:0]             len_q, len_d, count_q, count_d;
  logic [7:0]             byte_q, byte_d;
  logic                   done_q, done_d, dma_wr;
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    dst_d   = dst_q;
    len_d   = len_q;
    count_d = count_q;
    byte_d  = byte_q;
    done_d  = done_clr ? 1'b0 : done_q;
    case (state_q)
      IDLE: if (cfg_we) begin
        case (cfg_addr)
          2'd0: page_d = PW'(cfg_data);
          2'd1: dst_d[7:0] = cfg_data;
          2'd2: dst_d[VRAM_ADDR_W-1:8] = cfg_data[VRAM_ADDR_W-9:0];
          default: begin
            len_d   = {cfg_data == 8'd0, cfg_data};
            count_d = '0;
            done_d  = 1'b0;
            state_d = ARMED;
          end
        endcase
      end
      ARMED: state_d = in_vblank ? FETCH : ARMED;
      FETCH: if (src_ack) begin
        byte_d  = src_data;
        state_d = WRITE;
      end
      // a CPU write steals the port; the DMA byte simply retries next cycle
      WRITE: if (!cpu_vram_we) begin
        count_d = count_q + 9'd1;
        state_d = (count_d == len_q) ? DONE : in_vblank ? FETCH : ARMED;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_12_5875 or negedge rst_B) begin
    if (!rst_B) begin
      state_q <= IDLE;
      page_q  <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      count_q <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      count_q <= count_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
    end
  end
  assign dma_wr    = state_q == WRITE;
  assign src_req   = state_q == FETCH;
  assign src_addr  = {page_q, count_q[7:0]};
  assign vram_we   = cpu_vram_we | dma_wr;
  assign vram_addr = cpu_vram_we ? cpu_vram_addr : dma_wr ? dst_q + VRAM_ADDR_W'(count_q) : '0;
  assign vram_data = cpu_vram_we ? cpu_vram_data : dma_wr ? byte_q : 8'd0;
  assign busy      = state_q != IDLE;
  assign done_irq  = done_q;
endmodule

// File: tb/tb_vram_dma_controller.sv
// tb_vram_dma_controller: randomized bench with a queue-based transfer model checked every cycle
module tb_vram_dma_controller;
  logic clk = 1'b0, rst_B = 1'b0;
  logic cfg_we = 0, done_clr = 0, in_vblank = 0, src_ack, cpu_vram_we = 0;
  logic [1:0] cfg_addr = 0;
  logic [7:0] cfg_data = 0, src_data, cpu_vram_data = 0, vram_data;
  logic [11:0] cpu_vram_addr = 0, vram_addr;
  logic [15:0] src_addr;
  logic src_req, vram_we, busy, done_irq;
  int checks = 0, failures = 0;
  vram_dma_controller dut (
    .clk_12_5875(clk), .rst_B(rst_B), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .done_clr(done_clr), .in_vblank(in_vblank), .src_req(src_req), .src_addr(src_addr),
    .src_ack(src_ack), .src_data(src_data), .cpu_vram_we(cpu_vram_we), .cpu_vram_addr(cpu_vram_addr),
    .cpu_vram_data(cpu_vram_data), .vram_we(vram_we), .vram_addr(vram_addr), .vram_data(vram_data),
    .busy(busy), .done_irq(done_irq)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] src_fn(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  // model: pending writes of the active transfer as a queue of {addr,data}
  logic [19:0] m_q[$];
  logic [7:0] m_page;
  logic [11:0] m_dst;
  int m_len, m_written, n_dma;
  bit m_active, m_final, m_done, set_now, was_active, go_now, wrap_seen;
  logic [11:0] last_addr;
  logic [7:0] last_data;
  initial begin
    m_active = 0; m_final = 0; m_done = 0; m_page = 0; m_dst = 0; m_len = 0; m_written = 0;
    n_dma = 0; wrap_seen = 0; last_addr = 0; last_data = 0;
    forever begin
      @(negedge clk); #1;
      if (!rst_B) begin
        chk("rst_busy", busy, 0); chk("rst_src_req", src_req, 0); chk("rst_done", done_irq, 0);
        chk("rst_src_addr", src_addr, 0);
        if (!cpu_vram_we) begin
          chk("rst_vram_we", vram_we, 0); chk("rst_vram_addr", vram_addr, 0); chk("rst_vram_data", vram_data, 0);
        end
        m_q.delete(); m_active = 0; m_final = 0; m_done = 0; m_page = 0; m_dst = 0;
        continue;
      end
      chk("busy", busy, m_active);
      chk("done_irq", done_irq, m_done);
      if (cpu_vram_we) begin
        chk("cpu_we", vram_we, 1); chk("cpu_addr", vram_addr, cpu_vram_addr); chk("cpu_data", vram_data, cpu_vram_data);
      end else if (vram_we) begin
        if (m_q.size() == 0) chk("dma_unexpected_write", {vram_addr, vram_data}, 0);
        else begin
          logic [19:0] e;
          e = m_q.pop_front();
          chk("dma_addr", vram_addr, e[19:8]); chk("dma_data", vram_data, e[7:0]);
        end
        m_written++; n_dma++; last_addr = vram_addr; last_data = vram_data;
        if (vram_addr == 12'h000) wrap_seen = 1;
      end
      if (src_req) begin
        chk("src_req_when_idle", m_active, 1);
        chk("src_addr", src_addr, {m_page, 8'(m_written)});
      end
      set_now = 0; go_now = 0; was_active = m_active;
      if (was_active && m_written >= m_len) begin
        if (m_final) begin m_active = 0; m_final = 0; set_now = 1; end
        else m_final = 1;
      end else if (!was_active && cfg_we) begin
        case (cfg_addr)
          2'd0: m_page = cfg_data;
          2'd1: m_dst[7:0] = cfg_data;
          2'd2: m_dst[11:8] = cfg_data[3:0];
          default: begin
            go_now = 1; m_active = 1; m_written = 0; m_final = 0;
            m_len = (cfg_data == 0) ? 256 : int'(cfg_data);
            m_q.delete();
            for (int i = 0; i < m_len; i++) m_q.push_back({12'(m_dst + 12'(i)), src_fn({m_page, 8'(i)})});
          end
        endcase
      end
      m_done = set_now ? 1'b1 : (done_clr || go_now) ? 1'b0 : m_done;
    end
  end
  // source responder: ack after a fixed or random number of waiting cycles
  int ack_dly = 0, adly = 0, acnt = 0;
  bit ack_rand = 0;
  initial begin
    src_ack = 0; src_data = 0;
    forever begin
      @(negedge clk);
      if (src_req) begin
        if (acnt == 0) adly = ack_rand ? int'($urandom_range(0, 3)) : ack_dly;
        src_ack = (acnt == adly);
        src_data = src_ack ? src_fn(src_addr) : 8'($urandom);
        acnt++;
      end else begin
        src_ack = 0; acnt = 0;
      end
    end
  end
  task automatic cfg(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 0;
  endtask
  task automatic setup(input logic [7:0] page, input logic [11:0] dst);
    cfg(2'd0, page); cfg(2'd1, dst[7:0]); cfg(2'd2, {4'h0, dst[11:8]});
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 8000) begin n++; @(negedge clk); end
    if (busy) chk("timeout_idle", busy, 0);
  endtask
  task automatic run(input logic [7:0] page, input logic [11:0] dst, input logic [7:0] len, input bit noise);
    int n;
    in_vblank = 1;
    setup(page, dst);
    cfg(2'd3, len);
    n = 0;
    while (busy && n < 8000) begin
      if (noise) begin
        in_vblank = $urandom_range(0, 2) != 0;
        cpu_vram_we = $urandom_range(0, 3) == 0;
        cpu_vram_addr = 12'($urandom); cpu_vram_data = 8'($urandom);
        cfg_we = $urandom_range(0, 3) == 0; cfg_addr = 2'($urandom); cfg_data = 8'($urandom);
        done_clr = $urandom_range(0, 7) == 0;
      end
      n++;
      @(negedge clk);
    end
    if (busy) chk("timeout_run", busy, 0);
    cpu_vram_we = 0; cfg_we = 0; done_clr = 0; in_vblank = 1;
    @(negedge clk);
    chk("queue_empty", m_q.size(), 0);
  endtask
  initial begin
    int n, base;
    repeat (3) @(negedge clk);
    rst_B = 1;
    @(negedge clk);
    // basic 4-byte copy: 1 ARMED + 4x(FETCH,WRITE) + 1 DONE busy cycles
    in_vblank = 1;
    setup(8'h02, 12'h100);
    base = n_dma;
    cfg(2'd3, 8'd4);
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    chk("t1_busy_cycles", n, 10);
    chk("t1_done_irq", done_irq, 1);
    chk("t1_writes", n_dma - base, 4);
    chk("t1_last_addr", last_addr, 12'h103);
    chk("t1_last_data", last_data, 8'h79);
    done_clr = 1; @(negedge clk); done_clr = 0; @(negedge clk);
    chk("t1_done_cleared", done_irq, 0);
    // 256-byte copy wrapping the VRAM address space
    wrap_seen = 0; base = n_dma;
    run(8'h37, 12'hF80, 8'd0, 0);
    chk("t2_writes", n_dma - base, 256);
    chk("t2_wrap_seen", wrap_seen, 1);
    chk("t2_last_addr", last_addr, 12'h07F);
    // CPU holds the port for 3 cycles while DMA waits in WRITE
    setup(8'h05, 12'h200);
    cfg(2'd3, 8'd2);
    n = 0;
    while (!src_req && n < 20) begin n++; @(negedge clk); end
    chk("t3_saw_req", src_req, 1);
    @(negedge clk);
    base = n_dma;
    cpu_vram_we = 1; cpu_vram_addr = 12'h010; cpu_vram_data = 8'hAA;
    repeat (3) @(negedge clk);
    cpu_vram_we = 0;
    chk("t3_no_dma_during_cpu", n_dma - base, 0);
    @(negedge clk);
    chk("t3_dma_after_cpu", n_dma - base, 1);
    chk("t3_dma_addr", last_addr, 12'h200);
    wait_idle();
    // vblank drops during the third byte's write: pause in ARMED
    setup(8'h09, 12'h300);
    base = n_dma;
    cfg(2'd3, 8'd8);
    n = 0;
    while (!(vram_we && !cpu_vram_we && vram_addr == 12'h302) && n < 100) begin n++; @(negedge clk); end
    in_vblank = 0;
    repeat (10) begin
      @(negedge clk);
      chk("t4_paused_busy", busy, 1); chk("t4_paused_no_req", src_req, 0);
    end
    chk("t4_paused_writes", n_dma - base, 3);
    in_vblank = 1;
    wait_idle();
    chk("t4_writes", n_dma - base, 8);
    chk("t4_last_addr", last_addr, 12'h307);
    // slow source with config writes hammered while busy
    ack_dly = 5;
    setup(8'h11, 12'h400);
    base = n_dma;
    cfg(2'd3, 8'd3);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (n_dma > base) break;
      n += int'(src_req);
      cfg_we = 1; cfg_addr = 2'($urandom); cfg_data = 8'($urandom);
      @(negedge clk);
    end
    cfg_we = 0;
    chk("t5_req_cycles", n, 6);
    wait_idle();
    chk("t5_writes", n_dma - base, 3);
    chk("t5_last_addr", last_addr, 12'h402);
    // asynchronous reset mid-FETCH
    setup(8'h20, 12'h500);
    cfg(2'd3, 8'd4);
    n = 0;
    while (!src_req && n < 20) begin n++; @(negedge clk); end
    #2 rst_B = 0;
    #1;
    chk("t6_async_req", src_req, 0); chk("t6_async_busy", busy, 0); chk("t6_async_we", vram_we, 0);
    repeat (2) @(negedge clk);
    rst_B = 1; ack_dly = 0;
    @(negedge clk);
    setup(8'h30, 12'h0AB);
    base = n_dma;
    cfg(2'd3, 8'd1);
    wait_idle();
    chk("t6_writes", n_dma - base, 1);
    chk("t6_last_addr", last_addr, 12'h0AB);
    chk("t6_done", done_irq, 1);
    // randomized transfers with CPU, config, done_clr and vblank noise
    ack_rand = 1;
    for (int i = 0; i < 10; i++)
      run(8'($urandom), 12'($urandom), (i == 4) ? 8'd0 : 8'($urandom_range(1, 40)), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
